// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant_arbiter
//  Purpose  : Round-robin arbiter for one shared resource with a bounded grant
//             hold time and a mandatory dead cycle after every release.
//  Revision : 1.0  initial release
// ============================================================================
module rr_grant_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout_pulse
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [HC_W-1:0]   hold_cnt;

  logic              found;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  logic [N_REQ-1:0]  winner_onehot;

  // Rotating priority scan: first set request starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    winner_onehot = N_REQ'(1) << winner;
  end

  // Arbitration FSM; every output is registered so grant is glitch-free and
  // always equals the decode of grant_idx gated by grant_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      grant_idx     <= '0;
      grant_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
      ptr           <= '0;
      hold_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The pulse only lives for the single dead cycle after a forced release.
          timeout_pulse <= 1'b0;
          if (found) begin
            state       <= BUSY;
            grant       <= winner_onehot;
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end

        BUSY: begin
          hold_cnt <= hold_cnt + 1'b1;
          // Voluntary release takes precedence, so a winner dropping req on its
          // last allowed cycle does not raise the timeout flag.
          if (!req[grant_idx]) begin
            state         <= IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            timeout_pulse <= 1'b0;
            hold_cnt      <= '0;
            ptr           <= grant_idx + 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state         <= IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            timeout_pulse <= 1'b1;
            hold_cnt      <= '0;
            ptr           <= grant_idx + 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
